fp_addsub_seq: RTL and testbench

Multi-cycle sequencer for IEEE-754 single-precision add/subtract built around the shared 24-bit `BigALU` signed-magnitude mantissa adder. It accepts two operands and an op bit, then unpacks them and handles special values. It swaps and aligns the mantissas, drives `BigALU` through registered control ports, and normalizes the result by iterative left shifts. It then packs the result and pulses `done`. Rounding is truncation; denormals are flushed to zero.

---
 rtl/fp_addsub_seq.sv | 214 +++++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 single add/subtract sequencer driving an external BigALU mantissa adder.
// Latency 2 for special/zero operands, 4+k otherwise (k normalize shifts); start ignored while busy.
module fp_addsub_seq #(
    parameter int MANT_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       a,
    input  logic [31:0]       b,
    input  logic              op,
    output logic              busy,
    output logic              done,
    output logic [31:0]       result,
    output logic              overflow,
    output logic [MANT_W-1:0] alu_a,
    output logic [MANT_W-1:0] alu_b,
    output logic              alu_sign_a,
    output logic              alu_sign_b,
    output logic              alu_symbol,
    input  logic [MANT_W-1:0] alu_out,
    input  logic              alu_cout,
    input  logic              alu_sign_out
);
    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_EXEC, S_NORM} state_t;

    localparam logic [7:0]        MW8      = 8'(MANT_W);
    localparam logic [MANT_W-1:0] HIDDEN   = {1'b1, {(MANT_W-1){1'b0}}};
    localparam logic [MANT_W-1:0] NAN_MANT = {2'b11, {(MANT_W-2){1'b0}}};

    state_t            state_q, state_d;
    logic [31:0]       a_q, a_d, b_q, b_d, res_q, res_d;
    logic              op_q, op_d, busy_q, busy_d, done_q, done_d;
    logic              ovf_q, ovf_d, ovf_pend_q, ovf_pend_d;
    logic              sign_q, sign_d, swap_q, swap_d;
    logic [7:0]        exp_q, exp_d, diff_q, diff_d;
    logic [MANT_W-1:0] mant_q, mant_d, mant_s_q, mant_s_d;
    logic [MANT_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic              alu_sa_q, alu_sa_d, alu_sb_q, alu_sb_d, alu_sym_q, alu_sym_d;

    logic [7:0] ea, eb, exp_inc;
    logic       sa, sbe, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;

    always_comb begin
        ea      = a_q[30:23];
        eb      = b_q[30:23];
        sa      = a_q[31];
        sbe     = b_q[31] ^ op_q;
        a_zero  = (ea == 8'd0);
        b_zero  = (eb == 8'd0);
        a_nan   = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
        b_nan   = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
        a_inf   = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
        b_inf   = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
        exp_inc = exp_q + 8'd1;

        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        res_d      = res_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        ovf_pend_d = ovf_pend_q;
        sign_d     = sign_q;
        swap_d     = swap_q;
        exp_d      = exp_q;
        diff_d     = diff_q;
        mant_d     = mant_q;
        mant_s_d   = mant_s_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sa_d   = alu_sa_q;
        alu_sb_d   = alu_sb_q;
        alu_sym_d  = alu_sym_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    a_d        = a;
                    b_d        = b;
                    op_d       = op;
                    busy_d     = 1'b1;
                    ovf_d      = 1'b0;
                    ovf_pend_d = 1'b0;
                    state_d    = S_UNPACK;
                end
            end
            S_UNPACK: begin
                // Specials are staged as an already-normalized value so NORM packs them next cycle.
                state_d = S_NORM;
                if (a_nan || b_nan || (a_inf && b_inf && (sa != sbe))) begin
                    {sign_d, exp_d, mant_d} = {1'b0, 8'hFF, NAN_MANT};
                end else if (a_inf) begin
                    {sign_d, exp_d, mant_d} = {sa, 8'hFF, HIDDEN};
                end else if (b_inf) begin
                    {sign_d, exp_d, mant_d} = {sbe, 8'hFF, HIDDEN};
                end else if (a_zero && b_zero) begin
                    {sign_d, exp_d, mant_d} = {sa & sbe, 8'h00, HIDDEN};
                end else if (a_zero) begin
                    {sign_d, exp_d, mant_d} = {sbe, eb, 1'b1, b_q[22:0]};
                end else if (b_zero) begin
                    {sign_d, exp_d, mant_d} = {sa, ea, 1'b1, a_q[22:0]};
                end else begin
                    swap_d   = (eb > ea);
                    mant_d   = swap_d ? {1'b1, b_q[22:0]} : {1'b1, a_q[22:0]};
                    mant_s_d = swap_d ? {1'b1, a_q[22:0]} : {1'b1, b_q[22:0]};
                    exp_d    = swap_d ? eb : ea;
                    diff_d   = swap_d ? (eb - ea) : (ea - eb);
                    state_d  = S_ALIGN;
                end
            end
            S_ALIGN: begin
                alu_a_d   = mant_q;
                alu_b_d   = (diff_q >= MW8) ? '0 : (mant_s_q >> diff_q);
                alu_sa_d  = swap_q ? sbe : sa;
                alu_sb_d  = swap_q ? sa : b_q[31];
                alu_sym_d = swap_q ? 1'b0 : op_q;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_NORM;
                sign_d  = alu_sign_out;
                if (alu_cout) begin
                    if (exp_inc == 8'hFF) begin
                        mant_d     = HIDDEN;
                        ovf_pend_d = 1'b1;
                    end else begin
                        mant_d = {1'b1, alu_out[MANT_W-1:1]};
                    end
                    exp_d = exp_inc;
                end else if (alu_out == '0) begin
                    {sign_d, exp_d, mant_d} = {1'b0, 8'h00, HIDDEN};
                end else begin
                    mant_d = alu_out;
                end
            end
            S_NORM: begin
                if (mant_q[MANT_W-1]) begin
                    res_d   = {sign_q, exp_q, mant_q[MANT_W-2:MANT_W-24]};
                    ovf_d   = ovf_pend_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (exp_q == 8'd1) begin
                    res_d   = {sign_q, 31'd0};
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    mant_d = mant_q << 1;
                    exp_d  = exp_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 1'b0;
            res_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
            sign_q     <= 1'b0;
            swap_q     <= 1'b0;
            exp_q      <= '0;
            diff_q     <= '0;
            mant_q     <= '0;
            mant_s_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_sa_q   <= 1'b0;
            alu_sb_q   <= 1'b0;
            alu_sym_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            res_q      <= res_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            ovf_pend_q <= ovf_pend_d;
            sign_q     <= sign_d;
            swap_q     <= swap_d;
            exp_q      <= exp_d;
            diff_q     <= diff_d;
            mant_q     <= mant_d;
            mant_s_q   <= mant_s_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sa_q   <= alu_sa_d;
            alu_sb_q   <= alu_sb_d;
            alu_sym_q  <= alu_sym_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = res_q;
    assign overflow   = ovf_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sign_a = alu_sa_q;
    assign alu_sign_b = alu_sb_q;
    assign alu_symbol = alu_sym_q;
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq with a behavioural BigALU attached to the alu_* ports.
module tb_fp_addsub_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        op = 1'b0;
    logic        busy, done, overflow;
    logic [31:0] result;
    logic [23:0] alu_a, alu_b, alu_out;
    logic        alu_sign_a, alu_sign_b, alu_symbol, alu_cout, alu_sign_out;

    int checks = 0;
    int failures = 0;

    fp_addsub_seq #(.MANT_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .op(op),
        .busy(busy), .done(done), .result(result), .overflow(overflow),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sign_a(alu_sign_a), .alu_sign_b(alu_sign_b),
        .alu_symbol(alu_symbol), .alu_out(alu_out), .alu_cout(alu_cout),
        .alu_sign_out(alu_sign_out)
    );

    always #5 clk = ~clk;

    // BigALU: signed-magnitude adder
    always_comb begin
        alu_cout     = 1'b0;
        alu_out      = '0;
        alu_sign_out = alu_sign_a;
        if (!(alu_sign_a ^ alu_sign_b ^ alu_symbol)) begin
            {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
        end else if (alu_a >= alu_b) begin
            alu_out = alu_a - alu_b;
        end else begin
            alu_out      = alu_b - alu_a;
            alu_sign_out = ~alu_sign_a;
        end
    end

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] res;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic top,
                          output logic [31:0] r, output logic ovf, output int lat,
                          output logic busy_at_done);
        @(negedge clk);
        a = ta; b = tb_v; op = top; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1; r = 'x; ovf = 1'bx; busy_at_done = 1'bx;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i; r = result; ovf = overflow; busy_at_done = busy;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] r;
        logic        ovf, bz;
        int          lat, ndone;
        logic [31:0] first_res;

        vecs[0]  = '{"add_swap",   32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 4};
        vecs[1]  = '{"sub_3m1",    32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 4};
        vecs[2]  = '{"sub_k2",     32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 1'b0, 6};
        vecs[3]  = '{"ovf_max",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 4};
        vecs[4]  = '{"cancel",     32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 4};
        vecs[5]  = '{"inf_m_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 2};
        vecs[6]  = '{"zero_m_one", 32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 1'b0, 2};
        vecs[7]  = '{"neg_k1",     32'hBF800000, 32'h3F000000, 1'b0, 32'hBF000000, 1'b0, 5};
        vecs[8]  = '{"sub_swap",   32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 5};
        vecs[9]  = '{"far_align",  32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 1'b0, 4};
        vecs[10] = '{"flush",      32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 4};
        vecs[11] = '{"nan_in",     32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 2};
        vecs[12] = '{"negzero",    32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 2};
        vecs[13] = '{"inf_p_one",  32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b0, 2};
        vecs[14] = '{"b_zero",     32'h3F800000, 32'h80000000, 1'b0, 32'h3F800000, 1'b0, 2};
        vecs[15] = '{"inf_m_ninf", 32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000, 1'b0, 2};

        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_alu", {7'd0, alu_sign_a, alu_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 16; v++) begin
            run_op(vecs[v].a, vecs[v].b, vecs[v].op, r, ovf, lat, bz);
            chk({vecs[v].name, "_lat"}, lat, vecs[v].lat);
            chk({vecs[v].name, "_res"}, r, vecs[v].res);
            chk({vecs[v].name, "_ovf"}, {31'd0, ovf}, {31'd0, vecs[v].ovf});
            chk({vecs[v].name, "_busy_at_done"}, {31'd0, bz}, 32'd1);
            @(posedge clk);
            #1;
            chk({vecs[v].name, "_done_pulse"}, {31'd0, done}, 32'd0);
            chk({vecs[v].name, "_busy_fall"}, {31'd0, busy}, 32'd0);
        end

        // Second start while busy must be ignored: one done, first operation's result.
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40000000; op = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 32'h40400000; b = 32'h3F800000; op = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; first_res = '0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (ndone == 1) first_res = result;
            end
        end
        chk("ignored_start_done_count", ndone, 32'd1);
        chk("ignored_start_result", first_res, 32'h40400000);

        // Reset while normalizing: outputs clear at once and no done follows.
        @(negedge clk);
        a = 32'h3F800000; b = 32'h3F400000; op = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_result", result, 32'd0);
        chk("rst_mid_alu_a", {8'd0, alu_a}, 32'd0);
        chk("rst_mid_alu_b", {8'd0, alu_b}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("rst_mid_no_done", ndone, 32'd0);
        run_op(32'h3F800000, 32'h3F400000, 1'b1, r, ovf, lat, bz);
        chk("post_rst_lat", lat, 32'd6);
        chk("post_rst_res", r, 32'h3E800000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
